// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, deserialises MSB-first
// bytes and presents them with a valid/ack handshake plus error flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       fpga_clk,
    input  logic       nrst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy_rx
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(8);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               store_q, store_d;
    logic               ferr_q, ferr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // FSM state, counters and sampling strobes
    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            store_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            store_q   <= store_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        store_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {shreg_q[6:0], rx_s};
                    if (bit_cnt_q == BIT_W'(7)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        store_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                // a held-low line reports only once; wait for idle level
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser and registered handshake outputs
    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            sync_q    <= '1;
            dout      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy_rx   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            frame_err <= ferr_q;
            busy_rx   <= (state_d != IDLE);
            if (store_q) begin
                dout <= shreg_q;
            end
            if (store_q) begin
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            // an ack landing on the store cycle consumes the old byte, so no overrun
            if (store_q && rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes popped on each
// store, plus directed checks of latency, glitch, framing, overrun and reset.
module tb_uart_rx;

    localparam int unsigned CPB  = 6;
    localparam int unsigned SYNC = 2;
    localparam int unsigned LAT  = 60;

    logic       fpga_clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy_rx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int store_cyc = 0;
    int fall_cyc;
    int ferr_base;
    logic [7:0] sb_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .fpga_clk (fpga_clk),
        .nrst     (nrst),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .dout     (dout),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy_rx  (busy_rx)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: a store is a valid level with a fresh rise or a new dout value
    always @(negedge fpga_clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (rx_valid === 1'b1 && (!prev_valid || dout !== prev_dout)) begin
            store_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                check("sb_dout", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
        prev_valid = rx_valid;
        prev_dout  = dout;
    end

    task automatic step(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    // Drives the first nbits of an 8N1 frame, one bit per CPB cycles
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {1'b0, b, stop_bit};
        for (int i = 0; i < nbits; i++) begin
            rx = f[9-i];
            step(CPB);
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        check("ack_valid_clr", 32'(rx_valid), 32'd0);
        check("ack_ovr_clr", 32'(overrun), 32'd0);
    endtask

    initial begin
        nrst   = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        step(3);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy_rx), 32'd0);
        nrst = 1'b1;
        step(4);

        // Basic byte and latency from rx falling edge
        fall_cyc = cyc + 1;
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 10);
        step(3);
        check("a5_latency", 32'(store_cyc), 32'(fall_cyc + LAT));
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_ferr", 32'(ferr_cnt), 32'd0);
        check("a5_ovr", 32'(overrun), 32'd0);
        ack_pulse();

        // Short low glitch must not start a frame
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(10);
        check("glitch_busy", 32'(busy_rx), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 10);
        step(3);
        check("3c_valid", 32'(rx_valid), 32'd1);
        ack_pulse();

        // Stop bit low with a held-low line
        ferr_base = ferr_cnt;
        send_frame(8'h81, 1'b0, 10);
        step(30);
        check("brk_ferr_once", 32'(ferr_cnt - ferr_base), 32'd1);
        check("brk_valid", 32'(rx_valid), 32'd0);
        check("brk_busy", 32'(busy_rx), 32'd1);
        check("brk_dout", 32'(dout), 32'h3C);
        rx = 1'b1;
        step(5);
        check("brk_idle", 32'(busy_rx), 32'd0);
        sb_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 10);
        step(3);
        check("55_valid", 32'(rx_valid), 32'd1);
        check("55_ferr", 32'(ferr_cnt - ferr_base), 32'd1);
        ack_pulse();

        // Back-to-back frames without ack produce an overrun
        sb_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 10);
        sb_q.push_back(8'h34);
        send_frame(8'h34, 1'b1, 10);
        step(3);
        check("ovr_dout", 32'(dout), 32'h34);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_set", 32'(overrun), 32'd1);
        ack_pulse();

        // Ack coinciding with the second store
        sb_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 10);
        fall_cyc = cyc + 1;
        sb_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1, 10);
            begin
                for (int i = 0; i < 200 && cyc != fall_cyc + LAT - 1; i++) step(1);
                rx_ack = 1'b1;
                step(1);
                rx_ack = 1'b0;
            end
        join
        check("sim_dout", 32'(dout), 32'h99);
        check("sim_valid", 32'(rx_valid), 32'd1);
        check("sim_ovr", 32'(overrun), 32'd0);

        // Reset in the middle of data bit 4 discards the frame
        ferr_base = ferr_cnt;
        send_frame(8'hC3, 1'b1, 5);
        rx = 1'b0;
        step(2);
        nrst = 1'b0;
        step(1);
        check("mrst_dout", 32'(dout), 32'h00);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_ferr", 32'(frame_err), 32'd0);
        check("mrst_ovr", 32'(overrun), 32'd0);
        check("mrst_busy", 32'(busy_rx), 32'd0);
        nrst = 1'b1;
        rx   = 1'b1;
        step(10);
        sb_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 10);
        step(3);
        check("f0_dout", 32'(dout), 32'hF0);
        check("f0_valid", 32'(rx_valid), 32'd1);
        check("f0_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

        step(5);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the team's UART link. Deserialises 8N1 frames from the asynchronous `rx` pin into bytes, clocked by `fpga_clk`.
- Line format matches the team's transmitter:
  - idle high, one start bit (0), 8 data bits MSB-first, one stop bit (1);
  - each bit lasts CLKS_PER_BIT clocks.
- Presents each byte with a valid/ack handshake toward downstream logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 868, fpga_clk cycles per bit (100 MHz / 115200). Legal range ≥4. Simulation uses 6.
- SYNC_STAGES, 2, number of flops in the `rx` metastability synchroniser. Legal range ≥2.

Ports:
- fpga_clk  in  1  system clock; all logic on its rising edge
- nrst  in  1  reset, synchronous, active-low
- rx  in  1  asynchronous serial input, idle high
- rx_ack  in  1  consumer accepts `dout`; clears `rx_valid` and `overrun`
- dout  out  8  last received byte; held stable between updates
- rx_valid  out  1  `dout` holds an unacknowledged byte (level)
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  a byte was overwritten before it was acknowledged (sticky until `rx_ack`)
- busy_rx  out  1  high in every state except IDLE

Behaviour:
- Reset (nrst=0 at a clock edge) values:
  - synchroniser flops = 1, FSM = IDLE, counters = 0;
  - dout = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0, busy_rx = 0.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- `rx_s` is the output of the SYNC_STAGES flop chain. It lags `rx` by SYNC_STAGES cycles.
- HALF = CLKS_PER_BIT/2, truncated. The bit counter and clock counter are each sized with $clog2.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rx_s = 0, go to START with clk_cnt = 0. Call this cycle T0.
- START:
  - At T0+HALF, sample rx_s.
  - If 0: go to DATA with clk_cnt = 0 and bit_cnt = 0.
  - If 1: glitch; return to IDLE with no outputs.
- DATA:
  - Data bit k (k = 0..7, MSB first) is sampled at T0+HALF+(k+1)*CLKS_PER_BIT.
  - Shift left: shreg <= {shreg[6:0], rx_s}.
  - After k = 7, go to STOP.
- STOP:
  - Sample at T0+HALF+9*CLKS_PER_BIT.
  - If rx_s = 1:
    - on the next cycle, dout <= shreg and rx_valid <= 1;
    - overrun <= 1 if rx_valid was already 1 and rx_ack = 0 that cycle;
    - go to IDLE.
  - If rx_s = 0:
    - on the next cycle, frame_err pulses for 1 cycle;
    - dout, rx_valid and overrun are unchanged;
    - go to BREAK.
- BREAK:
  - Wait for rx_s = 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: rx_valid rises at T0+HALF+9*CLKS_PER_BIT+1. That is rx falling edge + SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles (60 for CLKS_PER_BIT=6, SYNC_STAGES=2).
- Handshake:
  - rx_ack while rx_valid = 1 clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid = 0 is ignored.
- Simultaneous rx_ack and a new-byte store in the same cycle:
  - the new byte loads into dout;
  - rx_valid stays 1;
  - overrun is not set.
- The receiver never stalls. A new frame is accepted regardless of rx_valid.
- Back-to-back frames: the next start edge is detected on the first IDLE cycle after STOP. No minimum gap beyond the stop bit.

Test Plan:
- CLKS_PER_BIT=6, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), no ack → dout=8'hA5, rx_valid rises exactly 60 cycles after the rx falling edge, frame_err=0, overrun=0.
- rx low for 2 cycles then high → FSM returns to IDLE, rx_valid stays 0, no frame_err; then 0x3C sent → dout=8'h3C.
- Send 0x81 with the stop bit forced 0 and the line held low for 30 cycles → one frame_err pulse, rx_valid=0, busy_rx high until the line returns high; then 0x55 → dout=8'h55, rx_valid=1.
- Send 0x12 and 0x34 back-to-back without ack → dout=8'h34, rx_valid=1, overrun=1; pulse rx_ack → rx_valid=0, overrun=0 next cycle.
- Assert rx_ack in the exact cycle the second byte stores → dout updated, rx_valid=1, overrun=0.
- Pull nrst low for 1 cycle at data bit 4 of a frame, then send 0xF0 → all outputs back to reset values; then dout=8'hF0, no frame_err.
